fifo_wr_arbiter: RTL
====================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of write requesters (2..8).
REQ-002 Parameter DWIDTH, default 32: data width per beat.
REQ-003 Parameter MAX_BURST, default 4: maximum beats accepted per grant (1..16).
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 req_valid  input  NREQ  per-requester beat valid.
REQ-007 req_data  input  NREQ*DWIDTH  per-requester beat data; requester i occupies bits [i*DWIDTH +: DWIDTH].
REQ-008 req_ready  output  NREQ  per-requester beat accepted when req_valid[i] and req_ready[i] are both high.
REQ-009 fifo_wreq  output  1  write strobe to the shared sync FIFO.
REQ-010 fifo_din  output  DWIDTH  write data to the shared sync FIFO.
REQ-011 fifo_full  input  1  FIFO full flag (FIFO holds DEPTH-1 entries).
REQ-012 grant_id  output  $clog2(NREQ)  index of the current owner.
REQ-013 busy  output  1  high while in state GRANT.
REQ-014 beat_total  output  16  count of beats written to the FIFO; wraps at 2^16.

Function
REQ-015 The FSM SHALL have two states, IDLE and GRANT; state, owner, last_grant, beat_cnt and beat_total are registers.
REQ-016 In IDLE with any req_valid high, the FSM SHALL select the first valid requester searching round-robin from last_grant+1 (mod NREQ), load owner and last_grant with that index, clear beat_cnt, and enter GRANT on the next edge (1-cycle arbitration latency).
REQ-017 In IDLE with no req_valid high, the FSM SHALL stay in IDLE with all registers unchanged.
REQ-018 In GRANT, req_ready[owner] SHALL equal !fifo_full (combinational); every other req_ready bit SHALL be 0.
REQ-019 In IDLE, all req_ready bits and fifo_wreq SHALL be 0.
REQ-020 fifo_wreq SHALL equal busy & req_valid[owner] & !fifo_full (combinational, no pipeline stage).
REQ-021 fifo_din SHALL equal the req_data slice of owner whenever busy is high; the value is don't-care otherwise.
REQ-022 Each cycle with fifo_wreq high SHALL increment beat_cnt and beat_total by 1.
REQ-023 On a beat where beat_cnt+1 == MAX_BURST, the FSM SHALL return to IDLE on that edge.
REQ-024 In GRANT, a cycle with req_valid[owner] low SHALL release the grant: return to IDLE on that edge with no beat counted.
REQ-025 In GRANT with fifo_full high and req_valid[owner] high, the FSM SHALL hold GRANT with no count change; a full-stall never releases the grant.
REQ-026 A requester that drops valid during a fifo_full stall SHALL lose the grant per REQ-024.
REQ-027 After a release, a requester requesting continuously SHALL be granted again no sooner than after every other valid requester has had one grant (round-robin fairness).
REQ-028 grant_id SHALL equal owner at all times.
REQ-029 The only side effect on the FIFO is fifo_wreq; the block SHALL never drive a FIFO read.

Reset
REQ-030 While rstn is low at an edge: state=IDLE, owner=0, last_grant=NREQ-1 (requester 0 wins first), beat_cnt=0, beat_total=0.
REQ-031 Resulting outputs: busy=0, grant_id=0, req_ready=0, fifo_wreq=0.
REQ-032 Reset asserted mid-burst SHALL abort the grant; no beat is accepted in a cycle where rstn is low, and burst progress is not retained.

Verification
REQ-033 Reset, then req_valid=4'b0101 held, fifo_full=0 -> grant to 0 after 1 cycle; 4 beats; IDLE; grant to 2; 4 beats; then grant to 0 again; beat_total=8 after 8 beats.
REQ-034 req_valid=4'b0010 single requester with 10 beats queued -> bursts of 4, 4, 2 with one IDLE cycle between bursts; beat_total=10.
REQ-035 Mid-burst (after 2 beats) fifo_full=1 for 5 cycles -> req_ready and fifo_wreq low, busy high, beat_cnt held at 2; after full deasserts, the remaining 2 beats complete.
REQ-036 Owner drops valid after 1 beat -> IDLE on that edge; with req_valid=4'b1000 pending, grant_id=3 one cycle later.
REQ-037 rstn low for 1 cycle during beat 3 of a burst -> busy=0, beat_total=0 next cycle, no fifo_wreq during reset; after reset, requester 0 is granted first.
REQ-038 All 4 requesters valid for 64 cycles, random fifo_full -> fifo_din always matches the owner slice; grants rotate 0,1,2,3; no beat lost or duplicated (scoreboard against FIFO contents).

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one requester at a time and forwards bursts of
// up to MAX_BURST beats into a shared synchronous FIFO.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DWIDTH    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DWIDTH-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     fifo_wreq,
    output logic [DWIDTH-1:0]        fifo_din,
    input  logic                     fifo_full,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy,
    output logic [15:0]              beat_total
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_BURST) + 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]        r_state;
    logic [IW-1:0]     r_owner;
    logic [IW-1:0]     r_last_grant;
    logic [CW-1:0]     r_beat_cnt;
    logic [15:0]       r_beat_total;

    logic [IW-1:0]     w_rot_idx [NREQ];
    logic [NREQ-1:0]   w_rot_valid;
    logic [DWIDTH-1:0] w_slice [NREQ];
    logic [IW-1:0]     w_pick;
    logic              w_any_valid;
    logic              w_busy;
    logic              w_owner_valid;
    logic              w_accept;
    logic              w_last_beat;

    // Slot gi of the rotated view is requester (last_grant + 1 + gi) mod NREQ,
    // so the lowest valid slot is the round-robin winner.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign w_rot_idx[gi]   = IW'((32'(r_last_grant) + 32'(gi) + 32'd1) % 32'(NREQ));
            assign w_rot_valid[gi] = req_valid[w_rot_idx[gi]];
            assign w_slice[gi]     = req_data[gi*DWIDTH +: DWIDTH];
            assign req_ready[gi]   = w_busy && rstn && (r_owner == IW'(gi)) && !fifo_full;
        end
    endgenerate

    always_comb begin
        w_pick = w_rot_idx[0];
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot_valid[k]) begin
                w_pick = w_rot_idx[k];
            end
        end
    end

    assign w_any_valid   = |req_valid;
    assign w_busy        = (r_state == ST_GRANT);
    assign w_owner_valid = req_valid[r_owner];
    // Gating with rstn keeps a reset cycle from completing a handshake mid-burst.
    assign w_accept      = w_busy && rstn && w_owner_valid && !fifo_full;
    assign w_last_beat   = ((r_beat_cnt + 1'b1) == CW'(MAX_BURST));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_last_grant <= IW'(NREQ - 1);
            r_beat_cnt   <= '0;
            r_beat_total <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_valid) begin
                        r_owner      <= w_pick;
                        r_last_grant <= w_pick;
                        r_beat_cnt   <= '0;
                        r_state      <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!w_owner_valid) begin
                        r_state <= ST_IDLE;
                    end else if (w_accept) begin
                        r_beat_cnt   <= r_beat_cnt + 1'b1;
                        r_beat_total <= r_beat_total + 16'd1;
                        if (w_last_beat) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy       = w_busy;
    assign grant_id   = r_owner;
    assign fifo_wreq  = w_accept;
    assign fifo_din   = w_slice[r_owner];
    assign beat_total = r_beat_total;

endmodule
